// File: rtl/ntt_stage_ctrl.sv
// Per-stage sequencer for the n=2048 NTT datapath. Kicks the 16-cycle burst
// counter once per stage, turns its count into bank read addresses, delays
// them by the butterfly latency for write-back, and drains between stages.
module ntt_stage_ctrl #(
  parameter int unsigned NumStages = 11,
  parameter int unsigned PipeLat   = 6,   // legal range 1..15
  parameter int unsigned StageW    = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_start_i,
  input  logic [3:0]        counter_in_i,
  output logic              cnt_start_o,
  output logic              rd_en_o,
  output logic [3:0]        rd_addr_o,
  output logic              wr_en_o,
  output logic [3:0]        wr_addr_o,
  output logic [StageW-1:0] stage_idx_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [2:0] {StIdle, StKick, StRun, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [StageW-1:0] stage_q, stage_d;
  logic [3:0]        drain_q, drain_d;
  // Each entry is {rd_en, rd_addr}; entry PipeLat-1 is the write-back view.
  logic [4:0]        pipe_q [PipeLat];

  // Control state: FSM, stage index and drain countdown.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      stage_q <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      drain_q <= drain_d;
    end
  end

  // Read-to-write delay line, advanced every cycle regardless of state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(PipeLat); i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= {rd_en_o, rd_addr_o};
      for (int i = 1; i < int'(PipeLat); i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // Next-state decode and per-state outputs.
  always_comb begin
    state_d     = state_q;
    stage_d     = stage_q;
    drain_d     = drain_q;
    cnt_start_o = 1'b0;
    rd_en_o     = 1'b0;
    rd_addr_o   = '0;
    done_o      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_start_i) begin
          stage_d = '0;
          state_d = StKick;
        end
      end
      StKick: begin
        cnt_start_o = 1'b1;
        state_d     = StRun;
      end
      StRun: begin
        rd_en_o   = 1'b1;
        rd_addr_o = counter_in_i;
        if (counter_in_i == 4'd15) begin
          state_d = StDrain;
          // Counts PipeLat cycles so the last write lands in the final drain cycle.
          drain_d = 4'(PipeLat - 1);
        end
      end
      StDrain: begin
        if (drain_q == 4'd0) begin
          if (stage_q == StageW'(NumStages - 1)) begin
            state_d = StDone;
          end else begin
            stage_d = stage_q + 1'b1;
            state_d = StKick;
          end
        end else begin
          drain_d = drain_q - 4'd1;
        end
      end
      StDone: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign wr_en_o     = pipe_q[PipeLat-1][4];
  assign wr_addr_o   = pipe_q[PipeLat-1][3:0];
  assign stage_idx_o = stage_q;
  assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_ntt_stage_ctrl.sv
// Bench for ntt_stage_ctrl: two instances (PipeLat 6 and 1), each fed by a
// model of the 16-cycle burst counter; per-cycle outputs are checked against
// a closed-form schedule, plus pulse counts and a read/write scoreboard.
module tb_ntt_stage_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b1, rst_b = 1'b1;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic [3:0] cnt_a, cnt_b;
  logic       kick_a, rd_en_a, wr_en_a, busy_a, done_a;
  logic       kick_b, rd_en_b, wr_en_b, busy_b, done_b;
  logic [3:0] rd_addr_a, wr_addr_a, stage_a;
  logic [3:0] rd_addr_b, wr_addr_b, stage_b;

  ntt_stage_ctrl #(.NumStages(11), .PipeLat(6), .StageW(4)) u_dut_a (
    .clk_i(clk), .rst_i(rst_a), .in_start_i(start_a), .counter_in_i(cnt_a),
    .cnt_start_o(kick_a), .rd_en_o(rd_en_a), .rd_addr_o(rd_addr_a),
    .wr_en_o(wr_en_a), .wr_addr_o(wr_addr_a), .stage_idx_o(stage_a),
    .busy_o(busy_a), .done_o(done_a)
  );

  ntt_stage_ctrl #(.NumStages(11), .PipeLat(1), .StageW(4)) u_dut_b (
    .clk_i(clk), .rst_i(rst_b), .in_start_i(start_b), .counter_in_i(cnt_b),
    .cnt_start_o(kick_b), .rd_en_o(rd_en_b), .rd_addr_o(rd_addr_b),
    .wr_en_o(wr_en_b), .wr_addr_o(wr_addr_b), .stage_idx_o(stage_b),
    .busy_o(busy_b), .done_o(done_b)
  );

  // Burst counter model: 0 in the cycle after the start pulse, then counting.
  always_ff @(posedge clk) begin
    if (rst_a || kick_a) cnt_a <= '0;
    else                 cnt_a <= cnt_a + 4'd1;
  end
  always_ff @(posedge clk) begin
    if (rst_b || kick_b) cnt_b <= '0;
    else                 cnt_b <= cnt_b + 4'd1;
  end

  logic [16:0] obs_a, obs_b;
  assign obs_a = {kick_a, rd_en_a, rd_addr_a, wr_en_a, wr_addr_a, stage_a, busy_a, done_a};
  assign obs_b = {kick_b, rd_en_b, rd_addr_b, wr_en_b, wr_addr_b, stage_b, busy_b, done_b};

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected {cnt_start, rd_en, rd_addr, wr_en, wr_addr, stage, busy, done}
  // in cycle c after the start edge, for latency pl. Stage length 17+pl.
  function automatic logic [16:0] exp_vec(input int c, input int pl);
    int         l;
    int         off;
    logic       ks, re, we, bz, dn;
    logic [3:0] ra, wa, st;
    l = 17 + pl;
    {ks, re, we, bz, dn} = '0;
    {ra, wa, st} = '0;
    if (c >= 1 && c <= 11 * l) begin
      off = (c - 1) % l;
      st  = 4'((c - 1) / l);
      bz  = 1'b1;
      ks  = (off == 0);
      if (off >= 1 && off <= 16) begin
        re = 1'b1;
        ra = 4'(off - 1);
      end
      if (off >= 1 + pl && off <= 16 + pl) begin
        we = 1'b1;
        wa = 4'(off - 1 - pl);
      end
    end else if (c == 11 * l + 1) begin
      st = 4'd10;
      bz = 1'b1;
      dn = 1'b1;
    end else if (c > 11 * l + 1) begin
      st = 4'd10;
    end
    return {ks, re, ra, we, wa, st, bz, dn};
  endfunction

  int rd_cnt [11][16];
  int wr_cnt [11][16];
  int first_rd [11];
  int last_wr [11];

  // Runs ncyc cycles of a sequence on instance sel (0: A, 1: B). With pulse,
  // start is raised first; otherwise the caller is already in cycle 1.
  task automatic run_dut(input bit sel, input int ncyc, input bit pulse, input bit hold,
                         input int rst_at, output int kicks, output int dones);
    logic [16:0] o;
    int          pl;
    int          s, a;
    pl = sel ? 1 : 6;
    kicks = 0;
    dones = 0;
    for (int i = 0; i < 11; i++) begin
      first_rd[i] = -1;
      last_wr[i]  = -1;
      for (int j = 0; j < 16; j++) begin
        rd_cnt[i][j] = 0;
        wr_cnt[i][j] = 0;
      end
    end
    if (pulse) begin
      if (sel) start_b = 1'b1; else start_a = 1'b1;
      @(posedge clk); #1;
    end
    for (int c = 1; c <= ncyc; c++) begin
      o = sel ? obs_b : obs_a;
      check_eq($sformatf("%s_cyc%0d", sel ? "b" : "a", c), 32'(o), 32'(exp_vec(c, pl)));
      if (o[16]) kicks++;
      if (o[0])  dones++;
      s = int'(o[5:2]);
      if (s > 10) s = 10;
      if (o[15]) begin
        a = int'(o[14:11]);
        rd_cnt[s][a]++;
        if (first_rd[s] < 0) first_rd[s] = c;
      end
      if (o[10]) begin
        a = int'(o[9:6]);
        wr_cnt[s][a]++;
        last_wr[s] = c;
      end
      if (!hold) begin
        if (sel) start_b = 1'b0; else start_a = 1'b0;
      end
      if (c == rst_at) begin
        if (sel) begin rst_b = 1'b1; start_b = 1'b0; end
        else     begin rst_a = 1'b1; start_a = 1'b0; end
      end
      if (c < ncyc) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic check_scoreboard(input string tag);
    int good, bad;
    good = 0;
    bad  = 0;
    for (int i = 0; i < 11; i++) begin
      for (int j = 0; j < 16; j++) begin
        if (rd_cnt[i][j] == 1 && wr_cnt[i][j] == 1) good++;
      end
      if (i < 10 && last_wr[i] >= first_rd[i+1]) bad++;
    end
    check_eq({tag, "_pairs"}, 32'(good), 32'd176);
    check_eq({tag, "_overlap"}, 32'(bad), 32'd0);
  endtask

  int kicks, dones;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_eq("a_reset", 32'(obs_a), 32'd0);
    check_eq("b_reset", 32'(obs_b), 32'd0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(posedge clk); #1;

    // Single start pulse, full run through idle at cycle 255.
    run_dut(1'b0, 255, 1'b1, 1'b0, 0, kicks, dones);
    check_eq("a1_kicks", 32'(kicks), 32'd11);
    check_eq("a1_dones", 32'(dones), 32'd1);
    check_scoreboard("a1");
    repeat (3) @(posedge clk);
    #1;
    check_eq("a_idle", 32'(obs_a), 32'(exp_vec(300, 6)));

    // Start held high: one run, re-accepted in the first idle cycle.
    run_dut(1'b0, 255, 1'b1, 1'b1, 0, kicks, dones);
    check_eq("a2_kicks", 32'(kicks), 32'd11);
    check_eq("a2_dones", 32'(dones), 32'd1);
    check_scoreboard("a2");
    @(posedge clk); #1;

    // Third run begins at cycle 256 (its cycle 1); reset during stage 1 RUN.
    run_dut(1'b0, 40, 1'b0, 1'b1, 40, kicks, dones);
    check_eq("a3_kicks", 32'(kicks), 32'd2);
    @(posedge clk); #1;
    check_eq("a3_abort", 32'(obs_a), 32'd0);
    check_eq("a3_nodone", 32'(dones), 32'd0);
    rst_a = 1'b0;
    @(posedge clk); #1;
    check_eq("a3_idle", 32'(obs_a), 32'd0);

    // Fresh run after abort starts from stage 0.
    run_dut(1'b0, 255, 1'b1, 1'b0, 0, kicks, dones);
    check_eq("a4_kicks", 32'(kicks), 32'd11);
    check_eq("a4_dones", 32'(dones), 32'd1);
    check_scoreboard("a4");

    // Minimum latency: 18-cycle stages, done at 199.
    run_dut(1'b1, 200, 1'b1, 1'b0, 0, kicks, dones);
    check_eq("b_kicks", 32'(kicks), 32'd11);
    check_eq("b_dones", 32'(dones), 32'd1);
    check_scoreboard("b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ntt_stage_ctrl.md
Name: ntt_stage_ctrl

Overview:
Per-stage sequencer for the n=2048 / p=128 NTT datapath. Drives the start pulse of the 16-cycle burst counter (4-bit count output) and consumes that count to produce bank read addresses and write-back addresses for each butterfly stage. Walks all NUM_STAGES stages back to back, drains the butterfly pipeline between stages, and signals completion to the top-level controller.

Parameters:
NUM_STAGES, 11, number of NTT stages (log2 2048)
PIPE_LAT, 6, butterfly read-to-write latency in cycles; legal range 1..15
STAGE_W, 4, width of stage index

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
in_start  in  1  start request from top controller; sampled only in IDLE
counter_in  in  4  count value from the 16-cycle burst counter
cnt_start  out  1  one-cycle start pulse to the burst counter
rd_en  out  1  bank read enable
rd_addr  out  4  bank read address within the 16-entry burst
wr_en  out  1  bank write-back enable (rd_en delayed PIPE_LAT cycles)
wr_addr  out  4  write-back address (rd_addr delayed PIPE_LAT cycles)
stage_idx  out  STAGE_W  current stage, 0..NUM_STAGES-1
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the last stage drains

Behaviour:
- Reset: state=IDLE. stage_idx=0. drain counter=0. Write-delay shift register cleared. All outputs 0. A reset during any state aborts the run with no done pulse. The burst counter shares rst.
- States:
  - IDLE: when in_start=1, clear stage_idx to 0 and go to KICK.
  - KICK: exactly one cycle with cnt_start=1; go to RUN.
  - RUN: rd_en=1 and rd_addr=counter_in (combinational). The counter shows 0 in the first RUN cycle and 15 in the 16th. When counter_in==15, go to DRAIN and load the drain counter with PIPE_LAT-1.
  - DRAIN: decrement the drain counter. When it reaches 0:
    - if stage_idx==NUM_STAGES-1, go to DONE;
    - otherwise increment stage_idx and go to KICK.
  - DONE: done=1 for one cycle; go to IDLE. stage_idx holds its final value until the next start.
- Write path:
  - PIPE_LAT-deep shift register of {rd_en, rd_addr}, advanced every cycle in all states.
  - wr_en and wr_addr are its output.
  - The last write of a stage lands in the final DRAIN cycle, so stages never overlap.
- Timing (in_start seen at edge 0, PIPE_LAT=6):
  - Cycle 1 is KICK; RUN is cycles 2..17; DRAIN is cycles 18..23; the next KICK is cycle 24.
  - Each stage takes 1+16+PIPE_LAT cycles (23).
  - done rises in cycle 254 (11*23+1); busy falls in cycle 255.
- in_start while busy: ignored, with no restart and no queuing.
- in_start in the same cycle as DONE: ignored. It is accepted on the next IDLE cycle.
- counter_in is ignored outside RUN.
- stage_idx changes only on the DRAIN-to-KICK transition and on IDLE start. It never wraps past NUM_STAGES-1.

Test Plan:
- Reset then a single in_start pulse -> cnt_start high in cycle 1 only. rd_en high in cycles 2..17 with rd_addr 0..15. wr_en high in cycles 8..23 with wr_addr 0..15.
- Full run, NUM_STAGES=11, PIPE_LAT=6 -> 11 cnt_start pulses at cycles 1, 24, 47, ... 231. stage_idx steps 0..10. done pulses once at cycle 254. busy is low from cycle 255.
- in_start held high for the whole run -> exactly one run. A second run starts at the first IDLE cycle (cycle 255, KICK in 256). No extra cnt_start pulses mid-run.
- rst asserted in cycle 40 (stage 1, RUN) -> next cycle all outputs 0, state IDLE, no done pulse. A fresh in_start afterwards runs a complete 254-cycle sequence starting from stage 0.
- PIPE_LAT=1 -> DRAIN is one cycle. Each stage takes 18 cycles. The wr_addr 15 write coincides with the DRAIN cycle. done arrives at cycle 11*18+1=199.
- Scoreboard over a full run -> every (stage, addr) pair is read exactly once and written exactly once, 176 of each. No write for stage s occurs after the first read for stage s+1.
